// File: rtl/sed_scheduler.sv
// sed_scheduler: launches periodic or on-demand SED configuration checks,
// drives the SED primitive controls and condenses its status into sticky
// error/timeout flags, a saturating error count and an interrupt pulse.
module sed_scheduler #(
  parameter int unsigned PERIOD  = 1024,
  parameter int unsigned TIMEOUT = 65535,
  parameter int unsigned CNTW    = 8
) (
  input  logic            CLK,
  input  logic            RSTN,
  input  logic            EN,
  input  logic            TRIG,
  input  logic            FRC,
  input  logic            CLR,
  input  logic            SEDERR,
  input  logic            SEDDONE,
  input  logic            SEDINPROG,
  output logic            SEDENABLE,
  output logic            SEDSTART,
  output logic            SEDFRCERR,
  output logic            BUSY,
  output logic            ERR_FLAG,
  output logic            TMO_FLAG,
  output logic [CNTW-1:0] ERR_CNT,
  output logic            IRQ
);

  localparam int unsigned PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [PW-1:0]   PER_LOAD = PW'(PERIOD - 1);
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [CNTW-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, START, RUN, CHECK} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   per_cnt, per_nxt;
  logic [TW-1:0]   tmo_cnt, tmo_nxt;
  logic            trig_pend, trig_nxt;
  logic            frc_pend, frc_pend_nxt;
  logic            frc_cur, frc_cur_nxt;
  logic            launch, err_evt, tmo_evt;
  logic            err_flag_nxt, tmo_flag_nxt;
  logic [CNTW-1:0] cnt_base, cnt_nxt;

  logic [2:0] sync1, sync2;
  logic       s_err, s_done, s_inprog;

  assign s_err    = sync2[2];
  assign s_done   = sync2[1];
  assign s_inprog = sync2[0];

  // Two-flop synchronizers for the primitive's asynchronous status lines
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {SEDERR, SEDDONE, SEDINPROG};
      sync2 <= sync1;
    end
  end

  // Next-state, counters, pending requests and event decode
  always_comb begin
    state_nxt    = state;
    per_nxt      = per_cnt;
    tmo_nxt      = tmo_cnt;
    trig_nxt     = trig_pend;
    frc_pend_nxt = frc_pend;
    frc_cur_nxt  = frc_cur;
    launch       = 1'b0;
    err_evt      = 1'b0;
    tmo_evt      = 1'b0;

    case (state)
      IDLE: begin
        if (TRIG || trig_pend) begin
          launch = 1'b1;
        end else if (EN) begin
          if (per_cnt == '0) launch = 1'b1;
          else               per_nxt = per_cnt - 1'b1;
        end else begin
          per_nxt = PER_LOAD;
        end
        if (launch) begin
          state_nxt = START;
          per_nxt   = PER_LOAD;
          tmo_nxt   = '0;
          trig_nxt  = 1'b0;
        end
      end
      START: begin
        if (tmo_cnt == TMO_LAST) begin
          tmo_evt = 1'b1;
        end else begin
          tmo_nxt = tmo_cnt + 1'b1;
          if (s_inprog) state_nxt = RUN;
        end
      end
      RUN: begin
        if (tmo_cnt == TMO_LAST) begin
          tmo_evt = 1'b1;
        end else begin
          tmo_nxt = tmo_cnt + 1'b1;
          if (s_done) state_nxt = CHECK;
        end
      end
      CHECK: begin
        err_evt   = s_err;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (tmo_evt) state_nxt = IDLE;

    // A trigger that cannot be serviced now is remembered once
    if (TRIG && (state != IDLE)) trig_nxt = 1'b1;

    // Force requests bind to a check until it leaves START, else to the next one
    if ((state == CHECK) || tmo_evt) begin
      frc_cur_nxt  = 1'b0;
      frc_pend_nxt = frc_pend | FRC;
    end else if ((state == START) || (state_nxt == START)) begin
      frc_cur_nxt  = frc_cur | frc_pend | FRC;
      frc_pend_nxt = 1'b0;
    end else begin
      frc_pend_nxt = frc_pend | FRC;
    end

    // Sticky flags and count: clear first, a same-cycle event still sets
    err_flag_nxt = err_evt | (ERR_FLAG & ~CLR);
    tmo_flag_nxt = tmo_evt | (TMO_FLAG & ~CLR);
    cnt_base     = CLR ? '0 : ERR_CNT;
    cnt_nxt      = cnt_base;
    if (err_evt && (cnt_base != CNT_MAX)) cnt_nxt = cnt_base + 1'b1;
  end

  // State, bookkeeping and registered outputs decoded from the next state
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= IDLE;
      per_cnt   <= PER_LOAD;
      tmo_cnt   <= '0;
      trig_pend <= 1'b0;
      frc_pend  <= 1'b0;
      frc_cur   <= 1'b0;
      SEDENABLE <= 1'b0;
      SEDSTART  <= 1'b0;
      SEDFRCERR <= 1'b0;
      BUSY      <= 1'b0;
      ERR_FLAG  <= 1'b0;
      TMO_FLAG  <= 1'b0;
      ERR_CNT   <= '0;
      IRQ       <= 1'b0;
    end else begin
      state     <= state_nxt;
      per_cnt   <= per_nxt;
      tmo_cnt   <= tmo_nxt;
      trig_pend <= trig_nxt;
      frc_pend  <= frc_pend_nxt;
      frc_cur   <= frc_cur_nxt;
      SEDENABLE <= (state_nxt != IDLE);
      SEDSTART  <= (state_nxt == START);
      SEDFRCERR <= frc_cur_nxt && ((state_nxt == START) || (state_nxt == RUN));
      BUSY      <= (state_nxt != IDLE);
      ERR_FLAG  <= err_flag_nxt;
      TMO_FLAG  <= tmo_flag_nxt;
      ERR_CNT   <= cnt_nxt;
      IRQ       <= err_evt | tmo_evt;
    end
  end

endmodule
